// File: rtl/rc4_prga_engine.sv
// RC4 keystream (PRGA) engine: walks a pre-scrambled S-box, swaps S[i]/S[j] and
// XORs the keystream into the encrypted message, one byte at a time.
module rc4_prga_engine #(
  parameter int unsigned LEN_W  = 5,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic [LEN_W:0]   len,
  output logic             ready,
  output logic             done,
  output logic [7:0]       s_addr,
  input  logic [7:0]       s_rdata,
  output logic [7:0]       s_wdata,
  output logic             s_wren,
  output logic [LEN_W-1:0] enc_addr,
  input  logic [7:0]       enc_rdata,
  output logic [LEN_W-1:0] dec_addr,
  output logic [7:0]       dec_wdata,
  output logic             dec_wren
);

  localparam int unsigned KW = LEN_W + 1;
  localparam logic [LEN_W:0] MAX_LEN  = {1'b1, {LEN_W{1'b0}}};
  localparam logic [1:0]     LAT_LAST = 2'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SI, S_RD_SJ, S_WR_I, S_WR_J, S_RD_F, S_WR_DEC, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    i_q, i_d, j_q, j_d;
  logic [7:0]    s_i_q, s_i_d, s_j_q, s_j_d;
  logic [7:0]    f_q, f_d, enc_q, enc_d;
  logic [KW-1:0] k_q, k_d, len_q, len_d;
  logic [1:0]    cnt_q, cnt_d;

  logic [KW-1:0] len_clamp, k_inc;
  logic          last_rd;

  logic             ready_d, done_d, s_wren_d, dec_wren_d;
  logic [7:0]       s_addr_d, s_wdata_d, dec_wdata_d;
  logic [LEN_W-1:0] enc_addr_d, dec_addr_d;

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    s_i_d     = s_i_q;
    s_j_d     = s_j_q;
    f_d       = f_q;
    enc_d     = enc_q;
    k_d       = k_q;
    len_d     = len_q;
    cnt_d     = '0;
    len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    last_rd   = (cnt_q == LAT_LAST);
    k_inc     = k_q + KW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d = len_clamp;
          k_d   = '0;
          if (!cont) begin
            i_d = '0;
            j_d = '0;
          end
          if (len_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            i_d     = (cont ? i_q : 8'd0) + 8'd1;
            state_d = S_RD_SI;
          end
        end
      end
      S_RD_SI: begin
        if (last_rd) begin
          s_i_d   = s_rdata;
          j_d     = j_q + s_rdata;
          state_d = S_RD_SJ;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RD_SJ: begin
        if (last_rd) begin
          s_j_d   = s_rdata;
          state_d = S_WR_I;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR_I: state_d = S_WR_J;
      S_WR_J: state_d = S_RD_F;
      S_RD_F: begin
        if (last_rd) begin
          f_d     = s_rdata;
          enc_d   = enc_rdata;
          state_d = S_WR_DEC;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_WR_DEC: begin
        k_d = k_inc;
        if (k_inc == len_q) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 8'd1;
          state_d = S_RD_SI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    done_d      = (state_d == S_DONE);
    s_addr_d    = '0;
    s_wdata_d   = '0;
    s_wren_d    = 1'b0;
    enc_addr_d  = '0;
    dec_addr_d  = '0;
    dec_wdata_d = '0;
    dec_wren_d  = 1'b0;
    case (state_d)
      S_RD_SI: s_addr_d = i_d;
      S_RD_SJ: s_addr_d = j_d;
      S_WR_I: begin
        s_addr_d  = i_d;
        s_wdata_d = s_j_d;
        s_wren_d  = 1'b1;
      end
      S_WR_J: begin
        s_addr_d  = j_d;
        s_wdata_d = s_i_d;
        s_wren_d  = 1'b1;
      end
      S_RD_F: begin
        s_addr_d   = s_i_d + s_j_d;
        enc_addr_d = k_d[LEN_W-1:0];
      end
      S_WR_DEC: begin
        dec_addr_d  = k_d[LEN_W-1:0];
        dec_wdata_d = f_d ^ enc_d;
        dec_wren_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      s_i_q     <= '0;
      s_j_q     <= '0;
      f_q       <= '0;
      enc_q     <= '0;
      k_q       <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wren    <= 1'b0;
      enc_addr  <= '0;
      dec_addr  <= '0;
      dec_wdata <= '0;
      dec_wren  <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      s_i_q     <= s_i_d;
      s_j_q     <= s_j_d;
      f_q       <= f_d;
      enc_q     <= enc_d;
      k_q       <= k_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      ready     <= ready_d;
      done      <= done_d;
      s_addr    <= s_addr_d;
      s_wdata   <= s_wdata_d;
      s_wren    <= s_wren_d;
      enc_addr  <= enc_addr_d;
      dec_addr  <= dec_addr_d;
      dec_wdata <= dec_wdata_d;
      dec_wren  <= dec_wren_d;
    end
  end

endmodule
